// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - multi-cycle conditional branch resolver for the multi-cycle MIPS core
module branch_sequencer #(
   parameter logic [4:0] LINK_REG = 5'd31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [2:0]  br_type,
   input  logic [31:0] pc,
   input  logic [15:0] imm,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic        done,
   output logic        taken,
   output logic        pc_we,
   output logic [31:0] pc_next,
   output logic        link_we,
   output logic [4:0]  link_addr,
   output logic [31:0] link_data
);

   localparam logic [2:0] BR_BEQ    = 3'b000;
   localparam logic [2:0] BR_BNE    = 3'b001;
   localparam logic [2:0] BR_BGEZ   = 3'b010;
   localparam logic [2:0] BR_BGTZ   = 3'b011;
   localparam logic [2:0] BR_BLEZ   = 3'b100;
   localparam logic [2:0] BR_BLTZ   = 3'b101;
   localparam logic [2:0] BR_BGEZAL = 3'b110;
   localparam logic [2:0] BR_BLTZAL = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXT    = 2'd1,
      S_CMP    = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   state_t      state;

   // Operands captured at accept; the request inputs are free to change afterwards.
   logic [2:0]  type_q;
   logic [31:0] pc_q;
   logic [15:0] imm_q;
   logic [31:0] rs_q;
   logic [31:0] rt_q;

   // Addresses formed in EXT.
   logic [31:0] pc4_q;
   logic [31:0] target_q;

   logic [31:0] offset;
   logic        rs_neg;
   logic        rs_zero;
   logic        cond;
   logic        is_link;

   // Word offset: sign-extend the 16-bit field and scale by 4 (wraps silently mod 2^32).
   assign offset    = {{14{imm_q[15]}}, imm_q, 2'b00};
   assign rs_neg    = rs_q[31];
   assign rs_zero   = (rs_q == 32'd0);
   assign is_link   = (type_q == BR_BGEZAL) || (type_q == BR_BLTZAL);
   assign link_addr = LINK_REG;

   // Branch condition from the latched operands; rs compares are signed against zero.
   always_comb begin
      cond = 1'b0;
      case (type_q)
         BR_BEQ:    cond = (rs_q == rt_q);
         BR_BNE:    cond = (rs_q != rt_q);
         BR_BGEZ:   cond = !rs_neg;
         BR_BGTZ:   cond = !rs_neg && !rs_zero;
         BR_BLEZ:   cond = rs_neg || rs_zero;
         BR_BLTZ:   cond = rs_neg;
         BR_BGEZAL: cond = !rs_neg;
         BR_BLTZAL: cond = rs_neg;
         default:   cond = 1'b0;
      endcase
   end

   // Sequencer: IDLE -> EXT -> CMP -> COMMIT, with all outputs registered.
   // Commit strobes are loaded on the CMP->COMMIT edge so they coincide with COMMIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         type_q    <= 3'd0;
         pc_q      <= 32'd0;
         imm_q     <= 16'd0;
         rs_q      <= 32'd0;
         rt_q      <= 32'd0;
         pc4_q     <= 32'd0;
         target_q  <= 32'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         taken     <= 1'b0;
         pc_we     <= 1'b0;
         pc_next   <= 32'd0;
         link_we   <= 1'b0;
         link_data <= 32'd0;
      end else begin
         done    <= 1'b0;
         pc_we   <= 1'b0;
         link_we <= 1'b0;
         case (state)
            S_IDLE: begin
               // abort beats a simultaneous start
               if (start && !abort) begin
                  type_q <= br_type;
                  pc_q   <= pc;
                  imm_q  <= imm;
                  rs_q   <= rs_val;
                  rt_q   <= rt_val;
                  busy   <= 1'b1;
                  state  <= S_EXT;
               end
            end
            S_EXT: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  pc4_q    <= pc_q + 32'd4;
                  target_q <= pc_q + 32'd4 + offset;
                  state    <= S_CMP;
               end
            end
            S_CMP: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  taken     <= cond;
                  pc_next   <= cond ? target_q : pc4_q;
                  link_data <= pc4_q;
                  done      <= 1'b1;
                  pc_we     <= 1'b1;
                  link_we   <= is_link;
                  state     <= S_COMMIT;
               end
            end
            S_COMMIT: begin
               // strobes are already out; abort is irrelevant here
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - self-checking bench for branch_sequencer
module tb_branch_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic [2:0]  br_type;
   logic [31:0] pc;
   logic [15:0] imm;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic        done;
   logic        taken;
   logic        pc_we;
   logic [31:0] pc_next;
   logic        link_we;
   logic [4:0]  link_addr;
   logic [31:0] link_data;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   branch_sequencer #(.LINK_REG(5'd31)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .br_type   (br_type),
      .pc        (pc),
      .imm       (imm),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .busy      (busy),
      .done      (done),
      .taken     (taken),
      .pc_we     (pc_we),
      .pc_next   (pc_next),
      .link_we   (link_we),
      .link_addr (link_addr),
      .link_data (link_data)
   );

   typedef struct {
      string       name;
      logic [2:0]  t;
      logic [31:0] p;
      logic [15:0] im;
      logic [31:0] rs;
      logic [31:0] rt;
      logic        exp_taken;
      logic [31:0] exp_next;
      logic        exp_lw;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Behavioural reference: branch rules expressed with plain signed integer arithmetic.
   task automatic ref_model(input logic [2:0] t, input logic [31:0] p, input logic [15:0] im,
                            input logic [31:0] rs, input logic [31:0] rt,
                            output logic tk, output logic [31:0] nxt, output logic lw);
      int signed srs;
      int signed off;
      srs = int'($signed(rs));
      off = int'($signed(im));
      case (t)
         3'd0: tk = (rs == rt);
         3'd1: tk = (rs != rt);
         3'd2: tk = (srs >= 0);
         3'd3: tk = (srs > 0);
         3'd4: tk = (srs <= 0);
         3'd5: tk = (srs < 0);
         3'd6: tk = (srs >= 0);
         default: tk = (srs < 0);
      endcase
      nxt = tk ? (p + 32'd4 + 32'(off * 4)) : (p + 32'd4);
      lw  = (t == 3'd6) || (t == 3'd7);
   endtask

   task automatic drive_req(input logic [2:0] t, input logic [31:0] p, input logic [15:0] im,
                            input logic [31:0] rs, input logic [31:0] rt);
      br_type = t; pc = p; imm = im; rs_val = rs; rt_val = rt;
   endtask

   task automatic scramble_inputs;
      br_type = 3'($urandom);
      pc      = $urandom;
      imm     = 16'($urandom);
      rs_val  = $urandom;
      rt_val  = $urandom;
   endtask

   // One full request: accept, wait (bounded) for commit, check strobes and payload.
   task automatic run_branch(input string tag, input logic [2:0] t, input logic [31:0] p,
                             input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt,
                             input logic exp_taken, input logic [31:0] exp_next, input logic exp_lw);
      int waited;
      drive_req(t, p, im, rs, rt);
      start = 1'b1;
      tick();
      start = 1'b0;
      scramble_inputs();
      check({tag, ".busy_ext"}, 32'(busy), 32'd1);
      waited = 0;
      while (!done && waited < 8) begin
         tick();
         waited++;
      end
      check({tag, ".latency"}, waited, 32'd2);
      if (done) begin
         check({tag, ".taken"},     32'(taken),     32'(exp_taken));
         check({tag, ".pc_next"},   pc_next,        exp_next);
         check({tag, ".pc_we"},     32'(pc_we),     32'd1);
         check({tag, ".link_we"},   32'(link_we),   32'(exp_lw));
         check({tag, ".link_addr"}, 32'(link_addr), 32'd31);
         check({tag, ".link_data"}, link_data,      p + 32'd4);
      end
      tick();
      check({tag, ".busy_after"},  32'(busy),  32'd0);
      check({tag, ".pc_we_after"}, 32'(pc_we), 32'd0);
   endtask

   // Count commit strobes over a window; used to prove nothing was queued or leaked.
   task automatic count_strobes(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (pc_we || done || link_we) n++;
      end
   endtask

   initial begin
      int          n;
      int          first_c;
      int          second_c;
      int          n_commits;
      logic        tk;
      logic [31:0] nxt;
      logic        lw;
      logic [2:0]  rt3;
      logic [31:0] rrs;
      logic [31:0] rrt;

      vecs[0] = '{"beq_taken",     3'd0, 32'h0040_0010, 16'h0004, 32'd5,         32'd5, 1'b1, 32'h0040_0024, 1'b0};
      vecs[1] = '{"bne_not_taken", 3'd1, 32'h0040_0100, 16'hFFFE, 32'd7,         32'd7, 1'b0, 32'h0040_0104, 1'b0};
      vecs[2] = '{"bne_taken",     3'd1, 32'h0040_0100, 16'hFFFE, 32'd7,         32'd8, 1'b1, 32'h0040_00FC, 1'b0};
      vecs[3] = '{"bltzal",        3'd7, 32'h0040_0020, 16'h0010, 32'h8000_0000, 32'd0, 1'b1, 32'h0040_0064, 1'b1};
      vecs[4] = '{"bgezal_neg",    3'd6, 32'h0040_0020, 16'h0010, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h0040_0024, 1'b1};
      vecs[5] = '{"bgtz_zero",     3'd3, 32'h0000_1000, 16'h0008, 32'd0,         32'd0, 1'b0, 32'h0000_1004, 1'b0};
      vecs[6] = '{"blez_zero",     3'd4, 32'h0000_1000, 16'h0008, 32'd0,         32'd0, 1'b1, 32'h0000_1024, 1'b0};
      vecs[7] = '{"wrap",          3'd0, 32'hFFFF_FFF8, 16'h0001, 32'd0,         32'd0, 1'b1, 32'h0000_0000, 1'b0};
      vecs[8] = '{"bgez_zero",     3'd2, 32'h0000_2000, 16'hFFFF, 32'd0,         32'd9, 1'b1, 32'h0000_2000, 1'b0};
      vecs[9] = '{"bltz_pos",      3'd5, 32'h0000_2000, 16'hFFFF, 32'd1,         32'd9, 1'b0, 32'h0000_2004, 1'b0};

      rst = 1'b1; start = 1'b0; abort = 1'b0;
      drive_req(3'd0, 32'd0, 16'd0, 32'd0, 32'd0);
      tick();
      tick();
      check("reset.busy",      32'(busy),      32'd0);
      check("reset.done",      32'(done),      32'd0);
      check("reset.taken",     32'(taken),     32'd0);
      check("reset.pc_we",     32'(pc_we),     32'd0);
      check("reset.link_we",   32'(link_we),   32'd0);
      check("reset.pc_next",   pc_next,        32'd0);
      check("reset.link_data", link_data,      32'd0);
      check("reset.link_addr", 32'(link_addr), 32'd31);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 10; i++)
         run_branch(vecs[i].name, vecs[i].t, vecs[i].p, vecs[i].im, vecs[i].rs, vecs[i].rt,
                    vecs[i].exp_taken, vecs[i].exp_next, vecs[i].exp_lw);

      // Randomized requests against the reference model, biased toward compare boundaries.
      for (int i = 0; i < 40; i++) begin
         rt3 = 3'($urandom);
         case ($urandom_range(3, 0))
            0: rrs = 32'd0;
            1: rrs = 32'hFFFF_FFFF;
            2: rrs = 32'd1;
            default: rrs = $urandom;
         endcase
         rrt = ($urandom_range(1, 0) == 0) ? rrs : $urandom;
         drive_req(rt3, $urandom, 16'($urandom), rrs, rrt);
         ref_model(br_type, pc, imm, rs_val, rt_val, tk, nxt, lw);
         run_branch($sformatf("rand%0d", i), br_type, pc, imm, rs_val, rt_val, tk, nxt, lw);
      end

      // Reset asserted mid-CMP: strobes clear at once, nothing leaks afterwards.
      drive_req(3'd0, 32'h0040_0010, 16'h0004, 32'd5, 32'd5);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      check("rst_mid.busy",  32'(busy),  32'd0);
      check("rst_mid.pc_we", 32'(pc_we), 32'd0);
      check("rst_mid.done",  32'(done),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      count_strobes(6, n);
      check("rst_mid.no_strobe", n, 32'd0);

      // start during EXT is ignored and not queued.
      drive_req(3'd0, 32'h0040_0010, 16'h0004, 32'd5, 32'd5);
      start = 1'b1;
      tick();
      drive_req(3'd1, 32'h0000_5000, 16'h0100, 32'd1, 32'd2);
      tick();
      start = 1'b0;
      tick();
      check("start_in_ext.pc_we",   32'(pc_we), 32'd1);
      check("start_in_ext.pc_next", pc_next,    32'h0040_0024);
      count_strobes(6, n);
      check("start_in_ext.not_queued", n, 32'd0);

      // abort in CMP: no commit, busy falls on the next edge.
      drive_req(3'd7, 32'h0040_0020, 16'h0010, 32'h8000_0000, 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_cmp.busy",  32'(busy),  32'd0);
      check("abort_cmp.pc_we", 32'(pc_we), 32'd0);
      count_strobes(6, n);
      check("abort_cmp.no_strobe", n, 32'd0);

      // abort in EXT behaves the same.
      start = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_ext.busy", 32'(busy), 32'd0);
      count_strobes(5, n);
      check("abort_ext.no_strobe", n, 32'd0);

      // start together with abort in IDLE is not accepted.
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      check("start_abort.busy", 32'(busy), 32'd0);
      count_strobes(5, n);
      check("start_abort.no_strobe", n, 32'd0);

      // abort in COMMIT has no effect on the strobes already out.
      drive_req(3'd6, 32'h0040_0020, 16'h0010, 32'd3, 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      abort = 1'b1;
      check("abort_commit.pc_we",   32'(pc_we),   32'd1);
      check("abort_commit.link_we", 32'(link_we), 32'd1);
      check("abort_commit.pc_next", pc_next,      32'h0040_0064);
      tick();
      abort = 1'b0;
      check("abort_commit.busy_after", 32'(busy), 32'd0);

      // Back-to-back: start held high, commits land 4 cycles apart.
      drive_req(3'd0, 32'h0040_0010, 16'h0004, 32'd5, 32'd5);
      start = 1'b1;
      first_c = -1;
      second_c = -1;
      n_commits = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (pc_we) begin
            if (first_c < 0) first_c = c;
            else if (second_c < 0) second_c = c;
            n_commits++;
         end
      end
      start = 1'b0;
      check("b2b.first_commit", first_c, 32'd2);
      check("b2b.spacing",      second_c - first_c, 32'd4);
      check("b2b.count",        n_commits, 32'd3);
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
